hovalaag_sequencer: RTL and testbench
=====================================

# hovalaag_sequencer

Host-side controller for the Hovalaag wrapper's 10-bit one-hot address bus and 6-bit data bus. It accepts 32-bit instructions and 12-bit IN1/IN2 stream words on valid/ready handshakes. For each instruction it runs the load/execute/readback sequence and returns new PC, OUT words and debug bytes. It runs on `inv_clk`, so the wrapper samples every `hov_addr`/`hov_io_in` value on its `clk` edge half a cycle later.

## Interface
Parameters: none.

Ports:
- `inv_clk`  in  1  clock; inverted wrapper clock
- `reset`  in  1  synchronous, active-high
- `cmd_valid` / `cmd_ready`  in/out  1/1  instruction handshake
- `cmd_instr`  in  32  instruction word
- `in1_valid` / `in1_ready`  in/out  1/1  IN1 stream handshake
- `in1_data`  in  12  IN1 stream word
- `in2_valid` / `in2_ready`  in/out  1/1  IN2 stream handshake
- `in2_data`  in  12  IN2 stream word
- `res_valid` / `res_ready`  out/in  1/1  OUT result handshake
- `res_data`  out  12  OUT result word
- `res_chan`  out  1  0 = OUT1, 1 = OUT2
- `pc`  out  8  PC read back after the last execute
- `dbg_abcd`  out  32  {D,C,B,A} low bytes
- `busy`  out  1  state != IDLE
- `hov_addr`  out  10  one-hot wrapper address; all-zero = no-op
- `hov_io_in`  out  6  wrapper data in
- `hov_io_out`  in  8  wrapper data out

## Operation
- Registered state: FSM; `ir` (32); shadows `s1`, `s2` (12 each); flags `p1`, `p2` (IN pending); `ov`, `os`; `pc`; result regs.
- Every wrapper address is read and write. Any cycle that reads addr 6–9 must drive the matching shadow slice on `hov_io_in`: 6 → `s1[5:0]`, 7 → `s1[11:6]`, 8 → `s2[5:0]`, 9 → `s2[11:6]`. This keeps the wrapper's IN registers intact.
- States and the `hov_addr` bit each one drives (one cycle each unless noted):
  - IDLE: `cmd_ready`=1. On accept, latch `ir` and go to I1L if `p1`, else I2L if `p2`, else C0.
  - I1L (bit 6, `in1_data[5:0]`): holds while `!in1_valid`, driving `hov_addr`=0 while stalled.
  - I1H (bit 7, `in1_data[11:6]`): pulses `in1_ready`, loads `s1`, clears `p1`.
  - I2L / I2H (bits 8 / 9): same pattern for IN2, then C0.
  - C0..C3 (bits 0..3, `ir` 6-bit chunks): `hov_io_out` is sampled into `dbg_abcd` byte n.
  - C4 (bit 4, `ir[29:24]`).
  - EX (bit 5, `{4'b0, ir[31:30]}`): sample status; `p1|=io_out[0]`, `p2|=io_out[1]`, `ov=io_out[2]|io_out[3]`, `os=io_out[3]`.
  - PC (bit 6, `s1[5:0]`): `pc<=io_out`. Go to OL if `ov`, else IDLE.
  - OL (bit 7, `s1[11:6]`): `res_data[7:0]<=io_out`.
  - OH (bit 8, `s2[5:0]`): `res_data[11:8]<=io_out[3:0]`, `res_chan<=os`, `res_valid<=1`.
  - RW: `hov_addr`=0, waits for `res_ready`, then clears `res_valid` and goes to IDLE.
- IN1/IN2 words load in the 2-cycle pairs above. Unused streams must still be fed (e.g. valid tied high, data 0). IN loads always precede the instruction they serve.

## Timing
- Reset values: state IDLE; `p1`=`p2`=1, so both streams are primed before the first execute. `s1`, `s2`, `ir`, `pc`, `dbg_abcd`, `res_data`, `res_chan`, `ov`, `os` = 0. `res_valid`, `in*_ready` = 0; `cmd_ready`=1; `hov_addr`=0; `hov_io_in`=0.
- Outputs `hov_addr`, `hov_io_in` are registered. In state S, `hov_io_out` is sampled on the `inv_clk` edge that leaves S.
- Latency:
  - No IN load, no OUT: accept-to-IDLE is 8 cycles.
  - With OUT: `res_valid` rises 10 cycles after accept.
  - Each IN load adds 2 cycles plus any stall.
- `in*_ready` is a single-cycle pulse coincident with the I*H cycle; the word is consumed only if `in*_valid` is high there. A valid that drops between I*L and I*H returns to I*L.
- Status from EX reflects the instruction just issued. OUT/PC readback reflects post-execute state.
- `cmd_valid` arriving while `busy` is held off (`cmd_ready`=0). Only one instruction is ever in flight.
- Reset mid-sequence aborts immediately and returns to the reset values; partially loaded chunks are abandoned. `reset` must be asserted together with the wrapper's reset.

## Configuration
- `HOVSEQ_DBG_EN` defined: C0..C3 capture A–D into `dbg_abcd`.
- Undefined: `dbg_abcd` is tied to 0, the capture registers are removed, and the sequence and timing are unchanged.

## Test plan
- Reset, with both IN streams valid and words 0x123 / 0x456 → I1L/I1H/I2L/I2H drive `hov_io_in` 0x23, 0x04, 0x16, 0x11. `in1_ready` then `in2_ready` each pulse once, and `p1`=`p2`=0 before C0.
- `cmd_instr`=0x8000_0000 with `ir[14]`=0 and wrapper model status 0 → `hov_addr` sequence 0x001, 0x002, 0x004, 0x008, 0x010, 0x020 (`io_in`=0x02), 0x040 → IDLE; `res_valid` never rises.
- `cmd_instr` with bit14=1, bit13=1, model OUT=0xABC → `res_valid`=1, `res_data`=0xABC, `res_chan`=1. Hold `res_ready`=0 for 5 cycles → `busy` stays 1 and `cmd_ready`=0.
- Model returns status 0x01 at EX, next `cmd_valid` with `in1_valid`=0 for 4 cycles → I1L held with `hov_addr`=0. On `in1_valid`, the word loads, then C0 follows.
- During PC/OL/OH with `s1`=0x123, `s2`=0x456 → `hov_io_in` = 0x23, 0x04, 0x16 respectively.
- Assert `reset` in C2 → next cycle IDLE, `hov_addr`=0, `p1`=`p2`=1. With `HOVSEQ_DBG_EN` and model A–D = 0x11, 0x22, 0x33, 0x44, a full instruction gives `dbg_abcd`=0x44332211.

Source files
------------

// File: rtl/hovalaag_sequencer.sv
// rtl/hovalaag_sequencer.sv - Hovalaag wrapper load/execute/readback sequencer on inv_clk.
// HOVSEQ_DBG_EN: when defined, C0..C3 capture registers A-D into dbg_abcd; otherwise dbg_abcd is 0.
module hovalaag_sequencer (
  input  logic        inv_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instr,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [11:0] in1_data,
  input  logic        in2_valid,
  output logic        in2_ready,
  input  logic [11:0] in2_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [11:0] res_data,
  output logic        res_chan,
  output logic [7:0]  pc,
  output logic [31:0] dbg_abcd,
  output logic        busy,
  output logic [9:0]  hov_addr,
  output logic [5:0]  hov_io_in,
  input  logic [7:0]  hov_io_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_I1L, S_I1H, S_I2L, S_I2H,
    S_C0, S_C1, S_C2, S_C3, S_C4, S_EX, S_PC, S_OL, S_OH, S_RW
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [11:0] s1, s2;
  logic        p1, p2, ov, os;
  logic [31:0] bus_ir;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // On accept the instruction is not yet in ir, so C0 must be fed from cmd_instr.
  assign bus_ir = (state == S_IDLE) ? cmd_instr : ir;

  // Bus value registered on entry to state s. Reads of 6..9 carry the shadow so
  // the wrapper's IN registers are rewritten with what they already hold.
  function automatic logic [15:0] bus_for(state_t s, logic [31:0] instr);
    logic [15:0] b;
    b = 16'd0;
    case (s)
      S_I1L:   if (in1_valid) b = {10'h040, in1_data[5:0]};
      S_I1H:   b = {10'h080, in1_data[11:6]};
      S_I2L:   if (in2_valid) b = {10'h100, in2_data[5:0]};
      S_I2H:   b = {10'h200, in2_data[11:6]};
      S_C0:    b = {10'h001, instr[5:0]};
      S_C1:    b = {10'h002, instr[11:6]};
      S_C2:    b = {10'h004, instr[17:12]};
      S_C3:    b = {10'h008, instr[23:18]};
      S_C4:    b = {10'h010, instr[29:24]};
      S_EX:    b = {10'h020, 4'b0000, instr[31:30]};
      S_PC:    b = {10'h040, s1[5:0]};
      S_OL:    b = {10'h080, s1[11:6]};
      S_OH:    b = {10'h100, s2[5:0]};
      default: b = 16'd0;
    endcase
    return b;
  endfunction

  always_ff @(posedge inv_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= 32'd0;
      s1        <= 12'd0;
      s2        <= 12'd0;
      p1        <= 1'b1;
      p2        <= 1'b1;
      ov        <= 1'b0;
      os        <= 1'b0;
      pc        <= 8'd0;
      res_data  <= 12'd0;
      res_chan  <= 1'b0;
      res_valid <= 1'b0;
      in1_ready <= 1'b0;
      in2_ready <= 1'b0;
      hov_addr  <= 10'd0;
      hov_io_in <= 6'd0;
    end else begin
      in1_ready <= 1'b0;
      in2_ready <= 1'b0;
      hov_addr  <= 10'd0;
      hov_io_in <= 6'd0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            ir <= cmd_instr;
            if (p1) begin
              state <= S_I1L;
              {hov_addr, hov_io_in} <= bus_for(S_I1L, bus_ir);
            end else if (p2) begin
              state <= S_I2L;
              {hov_addr, hov_io_in} <= bus_for(S_I2L, bus_ir);
            end else begin
              state <= S_C0;
              {hov_addr, hov_io_in} <= bus_for(S_C0, bus_ir);
            end
          end
        end
        // The low half only counts once it was actually driven, i.e. valid was high on entry.
        S_I1L: begin
          if (hov_addr[6]) begin
            state     <= S_I1H;
            in1_ready <= 1'b1;
            {hov_addr, hov_io_in} <= bus_for(S_I1H, bus_ir);
          end else begin
            {hov_addr, hov_io_in} <= bus_for(S_I1L, bus_ir);
          end
        end
        S_I1H: begin
          if (in1_valid) begin
            s1 <= in1_data;
            p1 <= 1'b0;
            if (p2) begin
              state <= S_I2L;
              {hov_addr, hov_io_in} <= bus_for(S_I2L, bus_ir);
            end else begin
              state <= S_C0;
              {hov_addr, hov_io_in} <= bus_for(S_C0, bus_ir);
            end
          end else begin
            state <= S_I1L;
            {hov_addr, hov_io_in} <= bus_for(S_I1L, bus_ir);
          end
        end
        S_I2L: begin
          if (hov_addr[8]) begin
            state     <= S_I2H;
            in2_ready <= 1'b1;
            {hov_addr, hov_io_in} <= bus_for(S_I2H, bus_ir);
          end else begin
            {hov_addr, hov_io_in} <= bus_for(S_I2L, bus_ir);
          end
        end
        S_I2H: begin
          if (in2_valid) begin
            s2    <= in2_data;
            p2    <= 1'b0;
            state <= S_C0;
            {hov_addr, hov_io_in} <= bus_for(S_C0, bus_ir);
          end else begin
            state <= S_I2L;
            {hov_addr, hov_io_in} <= bus_for(S_I2L, bus_ir);
          end
        end
        S_C0: begin
          state <= S_C1;
          {hov_addr, hov_io_in} <= bus_for(S_C1, bus_ir);
        end
        S_C1: begin
          state <= S_C2;
          {hov_addr, hov_io_in} <= bus_for(S_C2, bus_ir);
        end
        S_C2: begin
          state <= S_C3;
          {hov_addr, hov_io_in} <= bus_for(S_C3, bus_ir);
        end
        S_C3: begin
          state <= S_C4;
          {hov_addr, hov_io_in} <= bus_for(S_C4, bus_ir);
        end
        S_C4: begin
          state <= S_EX;
          {hov_addr, hov_io_in} <= bus_for(S_EX, bus_ir);
        end
        // Status bits: 0/1 = IN1/IN2 wanted, 2/3 = OUT1/OUT2 written.
        S_EX: begin
          p1    <= p1 | hov_io_out[0];
          p2    <= p2 | hov_io_out[1];
          ov    <= hov_io_out[2] | hov_io_out[3];
          os    <= hov_io_out[3];
          state <= S_PC;
          {hov_addr, hov_io_in} <= bus_for(S_PC, bus_ir);
        end
        S_PC: begin
          pc <= hov_io_out;
          if (ov) begin
            state <= S_OL;
            {hov_addr, hov_io_in} <= bus_for(S_OL, bus_ir);
          end else begin
            state <= S_IDLE;
          end
        end
        S_OL: begin
          res_data[7:0] <= hov_io_out;
          state         <= S_OH;
          {hov_addr, hov_io_in} <= bus_for(S_OH, bus_ir);
        end
        S_OH: begin
          res_data[11:8] <= hov_io_out[3:0];
          res_chan       <= os;
          res_valid      <= 1'b1;
          state          <= S_RW;
        end
        S_RW: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HOVSEQ_DBG_EN
  logic [31:0] dbg_q;

  always_ff @(posedge inv_clk) begin
    if (reset) begin
      dbg_q <= 32'd0;
    end else begin
      case (state)
        S_C0:    dbg_q[7:0]   <= hov_io_out;
        S_C1:    dbg_q[15:8]  <= hov_io_out;
        S_C2:    dbg_q[23:16] <= hov_io_out;
        S_C3:    dbg_q[31:24] <= hov_io_out;
        default: dbg_q        <= dbg_q;
      endcase
    end
  end

  assign dbg_abcd = dbg_q;
`else
  assign dbg_abcd = 32'd0;
`endif

endmodule

// File: tb/tb_hovalaag_sequencer.sv
// tb/tb_hovalaag_sequencer.sv - randomized bench for hovalaag_sequencer against an expected bus-trace model.
module tb_hovalaag_sequencer;

  logic        inv_clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_instr;
  logic        in1_valid, in1_ready, in2_valid, in2_ready;
  logic [11:0] in1_data, in2_data;
  logic        res_valid, res_ready;
  logic [11:0] res_data;
  logic        res_chan;
  logic [7:0]  pc;
  logic [31:0] dbg_abcd;
  logic        busy;
  logic [9:0]  hov_addr;
  logic [5:0]  hov_io_in;
  logic [7:0]  hov_io_out;

  hovalaag_sequencer dut (
    .inv_clk(inv_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .in2_valid(in2_valid), .in2_ready(in2_ready), .in2_data(in2_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_chan(res_chan),
    .pc(pc), .dbg_abcd(dbg_abcd), .busy(busy),
    .hov_addr(hov_addr), .hov_io_in(hov_io_in), .hov_io_out(hov_io_out)
  );

  always #5 inv_clk = ~inv_clk;

  // Wrapper stand-in: register reads answer from the values chosen for this instruction.
  logic [31:0] m_abcd;
  logic [7:0]  m_status, m_pc;
  logic [11:0] m_out;

  always_comb begin
    hov_io_out = 8'h00;
    if (hov_addr[0])      hov_io_out = m_abcd[7:0];
    else if (hov_addr[1]) hov_io_out = m_abcd[15:8];
    else if (hov_addr[2]) hov_io_out = m_abcd[23:16];
    else if (hov_addr[3]) hov_io_out = m_abcd[31:24];
    else if (hov_addr[5]) hov_io_out = m_status;
    else if (hov_addr[6]) hov_io_out = m_pc;
    else if (hov_addr[7]) hov_io_out = m_out[7:0];
    else if (hov_addr[8]) hov_io_out = {4'b0000, m_out[11:8]};
  end

  int n_cmp = 0;
  int n_bad = 0;
  int tx = 0;

  logic        p1_m, p2_m;
  logic [11:0] s1_m, s2_m, w1, w2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // {cmd_ready, busy, res_valid, in1_ready, in2_ready, hov_addr, hov_io_in} for a busy cycle
  function automatic logic [20:0] ent(input logic rv, input logic r1, input logic r2,
                                      input logic [9:0] a, input logic [5:0] io);
    return {1'b0, 1'b1, rv, r1, r2, a, io};
  endfunction

  localparam logic [20:0] IDLE_ENT = 21'h100000;

  task automatic run_instr(input logic [31:0] instr, input logic [1:0] st_in, input logic [31:0] abcd,
                           input logic [7:0] pcv, input logic [11:0] outv, input int stall1,
                           input int stall2, input int hold, input bit abort);
    logic [20:0] exp_q[$];
    logic        load1, load2, ov, och;
    logic [11:0] s1n, s2n;
    logic [31:0] sh;
    int          in2_start, rw_start, abort_at, n, p;
    load1 = p1_m;
    load2 = p2_m;
    ov    = instr[14];
    och   = instr[13];
    s1n   = load1 ? w1 : s1_m;
    s2n   = load2 ? w2 : s2_m;
    m_abcd   = abcd;
    m_pc     = pcv;
    m_out    = outv;
    m_status = {4'b0000, ov & och, ov & ~och, st_in};
    if (load1) begin
      repeat (stall1) exp_q.push_back(ent(0, 0, 0, 10'h000, 6'h00));
      exp_q.push_back(ent(0, 0, 0, 10'h040, w1[5:0]));
      exp_q.push_back(ent(0, 1, 0, 10'h080, w1[11:6]));
    end
    in2_start = exp_q.size();
    if (load2) begin
      repeat (stall2) exp_q.push_back(ent(0, 0, 0, 10'h000, 6'h00));
      exp_q.push_back(ent(0, 0, 0, 10'h100, w2[5:0]));
      exp_q.push_back(ent(0, 0, 1, 10'h200, w2[11:6]));
    end
    abort_at = abort ? exp_q.size() + 2 : -1;
    for (int k = 0; k < 5; k++) begin
      sh = instr >> (6 * k);
      exp_q.push_back(ent(0, 0, 0, 10'h001 << k, sh[5:0]));
    end
    exp_q.push_back(ent(0, 0, 0, 10'h020, {4'b0000, instr[31:30]}));
    exp_q.push_back(ent(0, 0, 0, 10'h040, s1n[5:0]));
    rw_start = 1 << 20;
    if (ov) begin
      exp_q.push_back(ent(0, 0, 0, 10'h080, s1n[11:6]));
      exp_q.push_back(ent(0, 0, 0, 10'h100, s2n[5:0]));
      rw_start = exp_q.size();
      repeat (hold + 1) exp_q.push_back(ent(1, 0, 0, 10'h000, 6'h00));
    end
    exp_q.push_back(IDLE_ENT);
    n = exp_q.size();

    cmd_instr = instr;
    cmd_valid = 1'b1;
    in1_valid = !(load1 && stall1 > 0);
    in2_valid = !(load2 && in2_start == 0 && stall2 > 0);
    res_ready = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge inv_clk);
      check($sformatf("tx%0d.cyc%0d", tx, j),
            {11'd0, cmd_ready, busy, res_valid, in1_ready, in2_ready, hov_addr, hov_io_in}, {11'd0, exp_q[j]});
      if (j == abort_at) begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge inv_clk);
        check($sformatf("tx%0d.abort", tx),
              {11'd0, cmd_ready, busy, res_valid, in1_ready, in2_ready, hov_addr, hov_io_in}, {11'd0, IDLE_ENT});
        check($sformatf("tx%0d.abort_pc", tx), {24'd0, pc}, 32'd0);
        check($sformatf("tx%0d.abort_dbg", tx), dbg_abcd, 32'd0);
        reset = 1'b0;
        p1_m = 1'b1;
        p2_m = 1'b1;
        s1_m = 12'd0;
        s2_m = 12'd0;
        if (load1) w1 = 12'($urandom_range(4095));
        if (load2) w2 = 12'($urandom_range(4095));
        in1_data = w1;
        in2_data = w2;
        tx++;
        return;
      end
      p = j + 1;
      in1_valid = !(load1 && p < stall1);
      in2_valid = !(load2 && p >= in2_start && p < in2_start + stall2);
      res_ready = (p >= rw_start + hold + 1);
      if (j == 0) cmd_instr = $urandom;
      if (j == n - 1) cmd_valid = 1'b0;
    end
    res_ready = 1'b0;

    check($sformatf("tx%0d.pc", tx), {24'd0, pc}, {24'd0, pcv});
`ifdef HOVSEQ_DBG_EN
    check($sformatf("tx%0d.dbg", tx), dbg_abcd, abcd);
`else
    check($sformatf("tx%0d.dbg", tx), dbg_abcd, 32'd0);
`endif
    if (ov) begin
      check($sformatf("tx%0d.res_data", tx), {20'd0, res_data}, {20'd0, outv});
      check($sformatf("tx%0d.res_chan", tx), {31'd0, res_chan}, {31'd0, och});
    end

    if (load1) begin
      s1_m = w1;
      w1   = 12'($urandom_range(4095));
      p1_m = 1'b0;
    end
    if (load2) begin
      s2_m = w2;
      w2   = 12'($urandom_range(4095));
      p2_m = 1'b0;
    end
    p1_m = p1_m | st_in[0];
    p2_m = p2_m | st_in[1];
    in1_data = w1;
    in2_data = w2;
    tx++;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_instr = 32'd0;
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    res_ready = 1'b0;
    m_abcd    = 32'd0;
    m_status  = 8'd0;
    m_pc      = 8'd0;
    m_out     = 12'd0;
    p1_m = 1'b1;
    p2_m = 1'b1;
    s1_m = 12'd0;
    s2_m = 12'd0;
    w1   = 12'h123;
    w2   = 12'h456;
    in1_data = w1;
    in2_data = w2;
    repeat (3) @(negedge inv_clk);
    check("rst.ctrl", {11'd0, cmd_ready, busy, res_valid, in1_ready, in2_ready, hov_addr, hov_io_in},
          {11'd0, IDLE_ENT});
    check("rst.pc", {24'd0, pc}, 32'd0);
    check("rst.dbg", dbg_abcd, 32'd0);
    check("rst.res", {19'd0, res_chan, res_data}, 32'd0);
    reset = 1'b0;

    run_instr(32'h0000_6000, 2'b00, 32'h0102_0304, 8'h11, 12'hABC, 0, 0, 5, 1'b0);
    run_instr(32'h8000_0000, 2'b00, 32'h0506_0708, 8'h12, 12'h000, 0, 0, 0, 1'b0);
    run_instr(32'h1234_0000, 2'b01, 32'h090A_0B0C, 8'h13, 12'h000, 0, 0, 0, 1'b0);
    run_instr(32'h0000_4ABC, 2'b00, 32'h0D0E_0F10, 8'h14, 12'h5A5, 4, 0, 1, 1'b0);
    run_instr(32'hCAFE_F00D, 2'b11, 32'hDEAD_BEEF, 8'h15, 12'h321, 0, 0, 0, 1'b1);
    run_instr(32'h4000_4000, 2'b00, 32'h4433_2211, 8'h16, 12'h7E1, 1, 2, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_instr($urandom, 2'($urandom_range(3)), $urandom, 8'($urandom_range(255)),
                12'($urandom_range(4095)), $urandom_range(3), $urandom_range(3),
                $urandom_range(3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
